serial_bit_source: RTL and testbench
====================================

# serial_bit_source

Upstream stage of the serial sequence detector. Accepts parallel words through a valid/ready load handshake and shifts them out MSB-first, one bit per `clock`, on `x_out`. `x_out` drives the detector's serial `x_in`. Back-to-back words stream with no gap bit. When no word is in flight, the line is held at a fixed idle level.

## Interface
- `WIDTH`, default 8: word width in bits; legal range 2..32.
- `IDLE_BIT`, default 1'b0: level driven on `x_out` when no word is being shifted.
- `CNT_W`, default 8: width of the `words_sent` counter.

Ports:
- `clock` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high; sampled on `clock` rising edge.
- `data_in` input WIDTH: word to serialize; sampled only on a load transfer.
- `load_valid` input 1: a word is offered on `data_in`.
- `load_ready` output 1: block accepts a word this cycle.
- `x_out` output 1: serial bit stream, MSB first.
- `busy` output 1: a word is currently on `x_out`.
- `last` output 1: the bit on `x_out` this cycle is bit 0 (the final bit) of the current word.
- `words_sent` output CNT_W: count of completed words; wraps modulo 2^CNT_W.

## Operation
- Load transfer: `load_valid && load_ready` at a rising edge of `clock`.
- States:
  - IDLE: `busy`=0, `x_out`=IDLE_BIT.
  - SHIFT: `busy`=1, `x_out`=`shreg[WIDTH-1]`.
- Internal registers: `shreg` (WIDTH bits) and bit index `cnt`, ranging 0..WIDTH-1.
- `load_ready`:
  - 1 in IDLE.
  - 1 in SHIFT only when `cnt`==WIDTH-1 (the final bit).
  - 0 otherwise. Offers made mid-word are not accepted; upstream must hold `load_valid`.
- IDLE, on transfer: `shreg`<=`data_in`, `cnt`<=0, go to SHIFT.
- IDLE, without transfer: stay in IDLE.
- SHIFT with `cnt`<WIDTH-1: `shreg`<=`shreg`<<1 (zero fill), `cnt`<=`cnt`+1.
- SHIFT with `cnt`==WIDTH-1:
  - `words_sent` increments.
  - With transfer: reload `shreg` and set `cnt`<=0; stay in SHIFT. The stream is gapless.
  - Without transfer: go to IDLE.
- `last` = (state==SHIFT) && (`cnt`==WIDTH-1).
- `x_out`, `busy`, `last` and `load_ready` are decoded from registered state only. No combinational path runs from `load_valid` or `data_in` to any output.

## Timing
- Reset values:
  - state IDLE, `cnt`=0, `shreg`=0, `words_sent`=0.
  - Outputs: `x_out`=IDLE_BIT, `busy`=0, `last`=0, `load_ready`=1.
- Latency: a transfer at edge N puts the MSB on `x_out` during cycle N+1 and bit 0 during cycle N+WIDTH.
- `last` is high for exactly one cycle per word.
- Throughput: one word per WIDTH cycles when `load_valid` is held high.
- Reset mid-word: the word is abandoned. `words_sent` is not incremented, and the line returns to IDLE_BIT the cycle after the reset edge.
- Reset and transfer in the same cycle: reset wins and the word is dropped. Because `load_ready`=1 during reset, upstream must treat reset as a flush.
- `words_sent` wrap: 2^CNT_W−1 plus one completion gives 0; no sticky flag.

## Structure
- A shared package holds:
  - the state enum {ST_IDLE, ST_SHIFT};
  - default WIDTH and IDLE_BIT constants, shared with the detector-side testbench.
- No sub-module is required. `cnt` and `shreg` stay inline in one FSM module.
- The testbench instantiates this block feeding the sequence detector.

## Test plan
- Single word, WIDTH=8, `data_in`=8'b0111_0110 transferred at edge 0:
  - `x_out` = 0,1,1,1,0,1,1,0 in cycles 1..8, then IDLE_BIT=0 from cycle 9.
  - `last`=1 only in cycle 8; `words_sent`=1.
- Back-to-back: 8'hE0 then 8'hFF, with `load_valid` held high:
  - `load_ready` is low in cycles 1..7 and high in cycle 8.
  - 16 bits stream contiguously: 1110_0000_1111_1111. There is no idle bit between words.
  - `words_sent`=2.
- Mid-word hold: `load_valid` is asserted in cycle 3 of a word with a new value. The new word is not accepted until `cnt`==7, and its MSB appears in cycle 9.
- Reset mid-word: `reset`=1 at edge 4 of a word.
  - From cycle 5: `x_out`=IDLE_BIT, `busy`=0, `last`=0.
  - `words_sent` is unchanged.
  - A simultaneous `load_valid` is dropped.
- IDLE_BIT=1, WIDTH=4:
  - The line idles high.
  - Word 4'b0001 gives 0,0,0,1, then the line is high again.
  - `busy` is high for exactly 4 cycles.
- Counter wrap, CNT_W=2: five consecutive words give `words_sent` = 1,2,3,0,1.

Source files
------------

// File: rtl/serial_bit_source_pkg.sv
// Shared definitions for the serial bit source and the detector-side bench:
// FSM state encoding and default word geometry.
package serial_bit_source_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  localparam int   DEFAULT_WIDTH    = 8;
  localparam logic DEFAULT_IDLE_BIT = 1'b0;
  localparam int   DEFAULT_CNT_W    = 8;

endpackage

// File: rtl/serial_bit_source_if.sv
// Load handshake plus serial line and status for the serial bit source.
// master = upstream word producer / observer, slave = the serializer.
interface serial_bit_source_if
  import serial_bit_source_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
);

  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             x_out;
  logic             busy;
  logic             last;
  logic [CNT_W-1:0] words_sent;

  modport master (
    output data_in,
    output load_valid,
    input  load_ready,
    input  x_out,
    input  busy,
    input  last,
    input  words_sent
  );

  modport slave (
    input  data_in,
    input  load_valid,
    output load_ready,
    output x_out,
    output busy,
    output last,
    output words_sent
  );

endinterface

// File: rtl/serial_bit_source.sv
// Parallel-to-serial word source: accepts words over valid/ready and shifts
// them out MSB-first on x_out, gapless when words arrive back to back.
module serial_bit_source
  import serial_bit_source_pkg::*;
#(
  parameter int   WIDTH    = DEFAULT_WIDTH,
  parameter logic IDLE_BIT = DEFAULT_IDLE_BIT,
  parameter int   CNT_W    = DEFAULT_CNT_W
) (
  input logic                clock,
  input logic                reset,
  serial_bit_source_if.slave bus
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic [CNT_W-1:0] words_sent;

  logic final_bit;
  logic load_ready;
  logic transfer;

  // Everything visible outside is decoded from registers only.
  assign final_bit  = (state == ST_SHIFT) && (cnt == CNT_LAST);
  assign load_ready = (state == ST_IDLE) || final_bit;
  assign transfer   = bus.load_valid && load_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      shreg      <= '0;
      words_sent <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (transfer) begin
            shreg <= bus.data_in;
            cnt   <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cnt != CNT_LAST) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
            cnt   <= cnt + CW'(1);
          end else begin
            // Final bit: reload in place so the next word follows with no gap.
            words_sent <= words_sent + CNT_W'(1);
            if (transfer) begin
              shreg <= bus.data_in;
              cnt   <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.x_out      = (state == ST_SHIFT) ? shreg[WIDTH-1] : IDLE_BIT;
  assign bus.busy       = (state == ST_SHIFT);
  assign bus.last       = final_bit;
  assign bus.words_sent = words_sent;

endmodule

// File: tb/tb_serial_bit_source.sv
// Bench for serial_bit_source: directed scenarios and random traffic against a
// queue-of-pending-bits reference model, plus narrow-word and counter-wrap builds.
module tb_serial_bit_source;
  import serial_bit_source_pkg::*;

  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  logic rst2 = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  serial_bit_source_if #(.WIDTH(8), .CNT_W(8)) bus0 ();
  serial_bit_source_if #(.WIDTH(4), .CNT_W(8)) bus1 ();
  serial_bit_source_if #(.WIDTH(4), .CNT_W(2)) bus2 ();

  serial_bit_source #(.WIDTH(8), .IDLE_BIT(1'b0), .CNT_W(8)) dut0 (
    .clock(clk), .reset(rst0), .bus(bus0.slave));
  serial_bit_source #(.WIDTH(4), .IDLE_BIT(1'b1), .CNT_W(8)) dut1 (
    .clock(clk), .reset(rst1), .bus(bus1.slave));
  serial_bit_source #(.WIDTH(4), .IDLE_BIT(1'b0), .CNT_W(2)) dut2 (
    .clock(clk), .reset(rst2), .bus(bus2.slave));

  // Reference model for dut0: bits still to be put on the line, front = current bit.
  bit mq[$];
  int unsigned mws = 0;

  function automatic logic [11:0] model_out();
    logic b;
    b = (mq.size() > 0);
    return {b ? logic'(mq[0]) : 1'b0, b, logic'(mq.size() == 1),
            logic'(mq.size() <= 1), 8'(mws)};
  endfunction

  task automatic model_edge(input logic v, input logic [7:0] d, input logic r);
    bit rdy;
    bit dummy;
    if (r) begin
      mq.delete();
      mws = 0;
    end else begin
      rdy = (mq.size() <= 1);
      if (mq.size() > 0) begin
        dummy = mq.pop_front();
        if (mq.size() == 0) mws = (mws + 1) % 256;
      end
      if (v && rdy)
        for (int i = 7; i >= 0; i--) mq.push_back(d[i]);
    end
  endtask

  function automatic logic [11:0] obs0();
    return {bus0.x_out, bus0.busy, bus0.last, bus0.load_ready, bus0.words_sent};
  endfunction

  task automatic test_reset();
    logic [11:0] got;
    logic [11:0] exp;
    for (int c = 0; c < 3; c++) begin
      bus0.load_valid = 1'b1;
      bus0.data_in    = 8'hA5;
      rst0            = 1'b1;
      @(posedge clk);
      model_edge(1'b1, 8'hA5, 1'b1);
      @(negedge clk);
    end
    got = obs0();
    checks++;
    if (got !== 12'h100) begin
      failures++;
      $display("FAIL reset_values got=%h exp=%h", got, 12'h100);
    end
    exp = model_out();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL reset_model got=%h exp=%h", got, exp);
    end
    rst0            = 1'b0;
    bus0.load_valid = 1'b0;
  endtask

  task automatic test_single_word();
    logic [7:0]  w;
    logic [11:0] got;
    logic [11:0] exp;
    logic        ex;
    w = 8'b0111_0110;
    for (int c = 0; c <= 10; c++) begin
      bus0.load_valid = (c == 0);
      bus0.data_in    = w;
      rst0            = 1'b0;
      got = obs0();
      exp = model_out();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL single_word_model c=%0d got=%h exp=%h", c, got, exp);
      end
      ex = (c >= 1 && c <= 8) ? w[8-c] : 1'b0;
      checks++;
      if (bus0.x_out !== ex) begin
        failures++;
        $display("FAIL single_word_x c=%0d got=%b exp=%b", c, bus0.x_out, ex);
      end
      checks++;
      if (bus0.last !== logic'(c == 8)) begin
        failures++;
        $display("FAIL single_word_last c=%0d got=%b exp=%b", c, bus0.last, c == 8);
      end
      @(posedge clk);
      model_edge(c == 0, w, 1'b0);
      @(negedge clk);
    end
    checks++;
    if (bus0.words_sent !== 8'd1) begin
      failures++;
      $display("FAIL single_word_count got=%0d exp=1", bus0.words_sent);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] stream;
    logic [7:0]  d;
    logic [11:0] got;
    logic [11:0] exp;
    logic        ex;
    stream = 16'b1110_0000_1111_1111;
    for (int c = 0; c <= 18; c++) begin
      d = (c == 0) ? 8'hE0 : 8'hFF;
      bus0.load_valid = (c <= 8);
      bus0.data_in    = d;
      got = obs0();
      exp = model_out();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL b2b_model c=%0d got=%h exp=%h", c, got, exp);
      end
      ex = (c >= 1 && c <= 16) ? stream[16-c] : 1'b0;
      checks++;
      if (bus0.x_out !== ex || bus0.busy !== logic'(c >= 1 && c <= 16)) begin
        failures++;
        $display("FAIL b2b_stream c=%0d got x=%b busy=%b exp x=%b", c, bus0.x_out, bus0.busy, ex);
      end
      if (c >= 1 && c <= 8) begin
        checks++;
        if (bus0.load_ready !== logic'(c == 8)) begin
          failures++;
          $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, bus0.load_ready, c == 8);
        end
      end
      @(posedge clk);
      model_edge(c <= 8, d, 1'b0);
      @(negedge clk);
    end
    checks++;
    if (bus0.words_sent !== 8'd3) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=3", bus0.words_sent);
    end
  endtask

  task automatic test_mid_word_hold();
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  d;
    logic        v;
    logic [11:0] got;
    logic [11:0] exp;
    logic        ex;
    a = 8'h5A;
    b = 8'hC3;
    for (int c = 0; c <= 18; c++) begin
      v = (c == 0) || (c >= 3 && c <= 8);
      d = (c == 0) ? a : b;
      bus0.load_valid = v;
      bus0.data_in    = d;
      got = obs0();
      exp = model_out();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL hold_model c=%0d got=%h exp=%h", c, got, exp);
      end
      if (c >= 1 && c <= 8)       ex = a[8-c];
      else if (c >= 9 && c <= 16) ex = b[16-c];
      else                        ex = 1'b0;
      checks++;
      if (bus0.x_out !== ex) begin
        failures++;
        $display("FAIL hold_x c=%0d got=%b exp=%b", c, bus0.x_out, ex);
      end
      if (c >= 3 && c <= 8) begin
        checks++;
        if (bus0.load_ready !== logic'(c == 8)) begin
          failures++;
          $display("FAIL hold_ready c=%0d got=%b exp=%b", c, bus0.load_ready, c == 8);
        end
      end
      @(posedge clk);
      model_edge(v, d, 1'b0);
      @(negedge clk);
    end
    checks++;
    if (bus0.words_sent !== 8'd5) begin
      failures++;
      $display("FAIL hold_count got=%0d exp=5", bus0.words_sent);
    end
  endtask

  task automatic test_reset_mid_word();
    logic        v;
    logic        r;
    logic [7:0]  d;
    logic [11:0] got;
    logic [11:0] exp;
    rst0 = 1'b1;
    bus0.load_valid = 1'b0;
    @(posedge clk);
    model_edge(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    for (int c = 0; c <= 8; c++) begin
      r = (c == 4 || c == 5);
      v = (c == 0) || r;
      d = (c == 0) ? 8'hFF : 8'hAA;
      rst0            = r;
      bus0.load_valid = v;
      bus0.data_in    = d;
      got = obs0();
      exp = model_out();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL rst_mid_model c=%0d got=%h exp=%h", c, got, exp);
      end
      if (c >= 5) begin
        checks++;
        if (bus0.x_out !== 1'b0 || bus0.busy !== 1'b0 || bus0.last !== 1'b0) begin
          failures++;
          $display("FAIL rst_mid_idle c=%0d got x=%b busy=%b last=%b exp 0 0 0",
                   c, bus0.x_out, bus0.busy, bus0.last);
        end
      end
      @(posedge clk);
      model_edge(v, d, r);
      @(negedge clk);
    end
    checks++;
    if (bus0.words_sent !== 8'd0) begin
      failures++;
      $display("FAIL rst_mid_count got=%0d exp=0", bus0.words_sent);
    end
  endtask

  task automatic test_random();
    logic        v;
    logic        r;
    logic [7:0]  d;
    logic [11:0] got;
    logic [11:0] exp;
    for (int c = 0; c < 400; c++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 63) == 0);
      d = 8'($urandom);
      rst0            = r;
      bus0.load_valid = v;
      bus0.data_in    = d;
      got = obs0();
      exp = model_out();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL random c=%0d got=%h exp=%h", c, got, exp);
      end
      @(posedge clk);
      model_edge(v, d, r);
      @(negedge clk);
    end
    rst0 = 1'b0;
    bus0.load_valid = 1'b0;
  endtask

  task automatic test_idle_high();
    logic [3:0] w;
    logic       ex;
    logic       eb;
    int         busy_cycles;
    w = 4'b0001;
    busy_cycles = 0;
    rst1 = 1'b1;
    bus1.load_valid = 1'b0;
    bus1.data_in    = w;
    @(posedge clk);
    @(negedge clk);
    rst1 = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      bus1.load_valid = (c == 0);
      eb = (c >= 1 && c <= 4);
      ex = eb ? w[4-c] : 1'b1;
      checks++;
      if (bus1.x_out !== ex || bus1.busy !== eb) begin
        failures++;
        $display("FAIL idle_high c=%0d got x=%b busy=%b exp x=%b busy=%b",
                 c, bus1.x_out, bus1.busy, ex, eb);
      end
      if (bus1.busy === 1'b1) busy_cycles++;
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (busy_cycles != 4) begin
      failures++;
      $display("FAIL idle_high_busy_len got=%0d exp=4", busy_cycles);
    end
  endtask

  task automatic test_counter_wrap();
    int         done;
    logic [1:0] ew;
    rst2 = 1'b1;
    bus2.load_valid = 1'b0;
    bus2.data_in    = 4'hB;
    @(posedge clk);
    @(negedge clk);
    rst2 = 1'b0;
    for (int c = 0; c <= 22; c++) begin
      bus2.load_valid = (c <= 16);
      bus2.data_in    = 4'($urandom);
      done = (c >= 1) ? (c - 1) / 4 : 0;
      if (done > 5) done = 5;
      ew = 2'(done % 4);
      checks++;
      if (bus2.words_sent !== ew) begin
        failures++;
        $display("FAIL wrap_count c=%0d got=%0d exp=%0d", c, bus2.words_sent, ew);
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    bus0.load_valid = 1'b0;
    bus0.data_in    = '0;
    bus1.load_valid = 1'b0;
    bus1.data_in    = '0;
    bus2.load_valid = 1'b0;
    bus2.data_in    = '0;
    @(negedge clk);
    test_reset();
    test_single_word();
    test_back_to_back();
    test_mid_word_hold();
    test_reset_mid_word();
    test_random();
    test_idle_high();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
